phase_request_scheduler: RTL and testbench
==========================================

PHASE_REQUEST_SCHEDULER -- requirements
Module: phase_request_scheduler

Interface
REQ-001 Parameter MIN_GREEN, default 8: minimum main-phase green cycles before a pending request is served.
REQ-002 Parameter GREEN_T, default 6: turn/side phase green duration in cycles.
REQ-003 Parameter YELLOW_T, default 3: yellow duration in cycles.
REQ-004 Parameter ALLRED_T, default 2: all-red clearance duration in cycles; all four timing parameters SHALL be in the range 1..255.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 req_turn  in  1  M1 right-turn demand, level or pulse, sampled every cycle.
REQ-008 req_side  in  1  side-road demand, level or pulse, sampled every cycle.
REQ-009 emerg  in  1  emergency preemption request, level.
REQ-010 light_M1, light_M2, light_M1Turn, light_Side  out  3 each  lamp code {red, yellow, green}: 3'b100 = red, 3'b010 = yellow, 3'b001 = green.
REQ-011 phase  out  2  served phase: 0 = MAIN, 1 = TURN, 2 = SIDE.
REQ-012 pend  out  2  latched requests {side, turn}.

Function
REQ-013 States SHALL be ALLRED, GREEN and YELLOW; the current phase SHALL be held in a separate register.
REQ-014 A down-counter SHALL time each state, so that a state with duration N occupies exactly N clock cycles.
REQ-015 MAIN green: M1 and M2 green. TURN green: M1 and M1Turn green. SIDE green: Side green. All other lamps SHALL be red.
REQ-016 In YELLOW, every lamp that was green in the phase SHALL show yellow; in ALLRED, all lamps SHALL be red.
REQ-017 Lamps SHALL be decoded combinationally from the registered state and phase, with zero added latency.
REQ-018 A req_turn or req_side high in any cycle SHALL set its pend bit.
REQ-019 A pend bit SHALL clear on the cycle its phase enters GREEN; clear takes priority over a request in the same cycle.
REQ-020 MAIN green SHALL hold indefinitely while pend == 0.
REQ-021 Once MIN_GREEN cycles have elapsed and pend != 0, MAIN green SHALL go to YELLOW, then ALLRED, then the GREEN of the selected phase.
REQ-022 Selection: if only one bit is pending, that phase is served; if both are pending, round-robin applies against the last served of TURN/SIDE, with SIDE winning after reset.
REQ-023 TURN/SIDE green SHALL last GREEN_T cycles, then go to YELLOW, then ALLRED, then MAIN green.
REQ-024 TURN and SIDE SHALL never be served back to back; MAIN always intervenes.

Reset
REQ-025 On rst: state = ALLRED, phase = MAIN, pend = 0, round-robin pointer = TURN-last, counter = ALLRED_T.
REQ-026 During and immediately after rst, all lamps SHALL be red; the first MAIN green SHALL appear ALLRED_T cycles after rst deasserts.
REQ-027 rst asserted mid-phase SHALL override all activity, including any lamp showing green, on the next edge.

Configuration
REQ-028 With EMERGENCY_PREEMPT_EN defined, emerg high SHALL act as follows:
- TURN/SIDE in GREEN: force YELLOW on the next edge.
- Then ALLRED, then MAIN green.
- MAIN green SHALL hold while emerg stays high, regardless of MIN_GREEN or pend.
- pend bits SHALL be retained.
- An ongoing YELLOW/ALLRED completes normally.
REQ-029 With EMERGENCY_PREEMPT_EN undefined, the emerg port SHALL exist but be ignored, and no preemption logic SHALL be synthesized.

Structure
REQ-030 Package tlc_pkg SHALL hold:
- the lamp code constants RED, YELLOW and GREEN;
- the phase enum MAIN, TURN and SIDE;
- the state enum ALLRED, GREEN and YELLOW.
REQ-031 The 8-bit loadable down-counter SHALL be a sub-module named phase_timer, with ports load, load_val and done.

Verification
REQ-032 Reset: rst high for 2 cycles -> all lamps 3'b100 and pend = 0; MAIN green (M1 = M2 = 3'b001) 2 cycles after release.
REQ-033 Turn request: 1-cycle req_turn pulse at MAIN green cycle 3 -> yellow at cycle 8 for 3 cycles, all-red for 2, then M1 + M1Turn green for 6 with pend[0] clear; MAIN returns after 3 + 2 more cycles.
REQ-034 Both requests pending: req_turn and req_side set together after reset -> SIDE served first, then MAIN for MIN_GREEN, then TURN.
REQ-035 Clear collision: req_side held high through SIDE green entry -> pend[1] = 0 after entry; a new req_side pulse during SIDE green re-sets pend[1].
REQ-036 Emergency (with EMERGENCY_PREEMPT_EN): emerg raised at SIDE green cycle 2 -> Side = 3'b010 next cycle, then all-red, then MAIN held for 20 cycles of emerg while pend[0] stays 1.
REQ-037 Mid-operation reset: rst asserted during TURN green -> all lamps red on the next edge and pend = 0.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared lamp codes, phase and state encodings for the phase request scheduler.
package tlc_pkg;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    typedef enum logic [1:0] {
        MAIN = 2'd0,
        TURN = 2'd1,
        SIDE = 2'd2
    } phase_t;

    typedef enum logic [1:0] {
        ST_ALLRED = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2
    } state_t;

    // A lamp that belongs to the served phase follows the state colour; all others stay red.
    function automatic logic [2:0] lamp_code(input state_t st, input logic lit);
        logic [2:0] code;
        code = RED;
        if (lit) begin
            case (st)
                ST_GREEN:  code = GREEN;
                ST_YELLOW: code = YELLOW;
                default:   code = RED;
            endcase
        end
        return code;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// 8-bit loadable down-counter; done flags the last cycle of a timed interval and stays set.
module phase_timer (
    input  logic       clk,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       done
);

    logic [7:0] count;

    // Saturating at 1 lets the main green idle with done held once its minimum has elapsed.
    always_ff @(posedge clk) begin
        if (load)
            count <= load_val;
        else if (count > 8'd1)
            count <= count - 8'd1;
    end

    assign done = (count <= 8'd1);

endmodule

// File: rtl/phase_request_scheduler.sv
// Three-phase signal scheduler with latched turn/side requests and round-robin service.
// Define EMERGENCY_PREEMPT_EN to let emerg cut short turn/side green and pin the main green.
module phase_request_scheduler
    import tlc_pkg::*;
#(
    parameter int MIN_GREEN = 8,
    parameter int GREEN_T   = 6,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_turn,
    input  logic       req_side,
    input  logic       emerg,
    output logic [2:0] light_M1,
    output logic [2:0] light_M2,
    output logic [2:0] light_M1Turn,
    output logic [2:0] light_Side,
    output logic [1:0] phase,
    output logic [1:0] pend
);

    localparam logic [7:0] MIN_GREEN_V = 8'(MIN_GREEN);
    localparam logic [7:0] GREEN_T_V   = 8'(GREEN_T);
    localparam logic [7:0] YELLOW_T_V  = 8'(YELLOW_T);
    localparam logic [7:0] ALLRED_T_V  = 8'(ALLRED_T);

    state_t     state, state_n;
    phase_t     phase_q, phase_n, last_q, last_n, sel;
    logic [1:0] pend_q, pend_n, clear;
    logic       done, load, preempt;
    logic [7:0] load_val, dur;

`ifdef EMERGENCY_PREEMPT_EN
    assign preempt = emerg;
`else
    logic unused_emerg;
    assign unused_emerg = emerg;
    assign preempt      = 1'b0;
`endif

    phase_timer u_timer (
        .clk      (clk),
        .load     (load),
        .load_val (load_val),
        .done     (done)
    );

    always_comb begin
        sel = MAIN;
        case (pend_q)
            2'b01:   sel = TURN;
            2'b10:   sel = SIDE;
            2'b11:   sel = (last_q == TURN) ? SIDE : TURN;
            default: sel = MAIN;
        endcase
    end

    // The phase register is retargeted as yellow ends, so ALLRED already knows which green follows.
    always_comb begin
        state_n = state;
        phase_n = phase_q;
        last_n  = last_q;
        clear   = 2'b00;
        case (state)
            ST_ALLRED: begin
                if (done) begin
                    state_n  = ST_GREEN;
                    clear[0] = (phase_q == TURN);
                    clear[1] = (phase_q == SIDE);
                end
            end
            ST_GREEN: begin
                if (phase_q == MAIN) begin
                    if (done && (pend_q != 2'b00) && !preempt)
                        state_n = ST_YELLOW;
                end else if (done || preempt) begin
                    state_n = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (done) begin
                    state_n = ST_ALLRED;
                    if (phase_q == MAIN) begin
                        phase_n = sel;
                        if (sel != MAIN)
                            last_n = sel;
                    end else begin
                        phase_n = MAIN;
                    end
                end
            end
            default: state_n = ST_ALLRED;
        endcase
    end

    assign pend_n = (pend_q | {req_side, req_turn}) & ~clear;

    always_comb begin
        dur = ALLRED_T_V;
        case (state_n)
            ST_GREEN:  dur = (phase_n == MAIN) ? MIN_GREEN_V : GREEN_T_V;
            ST_YELLOW: dur = YELLOW_T_V;
            default:   dur = ALLRED_T_V;
        endcase
    end

    assign load     = rst || (state_n != state);
    assign load_val = rst ? ALLRED_T_V : dur;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_ALLRED;
            phase_q <= MAIN;
            last_q  <= TURN;
            pend_q  <= 2'b00;
        end else begin
            state   <= state_n;
            phase_q <= phase_n;
            last_q  <= last_n;
            pend_q  <= pend_n;
        end
    end

    assign light_M1     = lamp_code(state, (phase_q == MAIN) || (phase_q == TURN));
    assign light_M2     = lamp_code(state, phase_q == MAIN);
    assign light_M1Turn = lamp_code(state, phase_q == TURN);
    assign light_Side   = lamp_code(state, phase_q == SIDE);
    assign phase        = phase_q;
    assign pend         = pend_q;

endmodule

// File: tb/tb_phase_request_scheduler.sv
// Scoreboard bench: each stimulus step queues the expected lamps/phase/pend, a negedge monitor checks them.
module tb_phase_request_scheduler;

    localparam logic [2:0] LR = 3'b100;
    localparam logic [2:0] LY = 3'b010;
    localparam logic [2:0] LG = 3'b001;

    typedef enum {V_RED, V_MAIN_G, V_MAIN_Y, V_TURN_G, V_TURN_Y, V_SIDE_G, V_SIDE_Y} view_t;

    typedef struct {
        logic [11:0] lamps;
        logic [1:0]  ph;
        bit          ph_dc;
        logic [1:0]  pd;
        string       nm;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_turn = 1'b0;
    logic       req_side = 1'b0;
    logic       emerg = 1'b0;
    logic [2:0] light_M1, light_M2, light_M1Turn, light_Side;
    logic [1:0] phase, pend;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    phase_request_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .req_turn     (req_turn),
        .req_side     (req_side),
        .emerg        (emerg),
        .light_M1     (light_M1),
        .light_M2     (light_M2),
        .light_M1Turn (light_M1Turn),
        .light_Side   (light_Side),
        .phase        (phase),
        .pend         (pend)
    );

    always #5 clk = ~clk;

    // Expectation describes the outputs seen in this cycle; the inputs set here act on the next edge.
    task applyStimulus(input logic r, input logic rt, input logic rs, input logic em,
                       input view_t v, input logic [1:0] ph, input logic [1:0] pd, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst      = r;
        req_turn = rt;
        req_side = rs;
        emerg    = em;
        case (v)
            V_MAIN_G: e.lamps = {LG, LG, LR, LR};
            V_MAIN_Y: e.lamps = {LY, LY, LR, LR};
            V_TURN_G: e.lamps = {LG, LR, LG, LR};
            V_TURN_Y: e.lamps = {LY, LR, LY, LR};
            V_SIDE_G: e.lamps = {LR, LR, LR, LG};
            V_SIDE_Y: e.lamps = {LR, LR, LR, LY};
            default:  e.lamps = {LR, LR, LR, LR};
        endcase
        e.ph    = ph;
        e.ph_dc = (ph === 2'd3);
        e.pd    = pd;
        e.nm    = nm;
        sb.push_back(e);
    endtask

    task checkOutput(input exp_t e);
        logic [11:0] act;
        act = {light_M1, light_M2, light_M1Turn, light_Side};
        checks++;
        if (act !== e.lamps || (!e.ph_dc && phase !== e.ph) || pend !== e.pd) begin
            errors++;
            $display("[TB] FAIL %s: got lamps=%h phase=%0d pend=%b, expected lamps=%h phase=%0d pend=%b",
                     e.nm, act, phase, pend, e.lamps, e.ph, e.pd);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0)
            checkOutput(sb.pop_front());
    end

    initial begin
        // Reset held two edges, then ALLRED_T cycles of all-red before the first main green.
        applyStimulus(1, 0, 0, 0, V_RED, 2'd0, 2'b00, "reset_hold");
        applyStimulus(0, 0, 0, 0, V_RED, 2'd0, 2'b00, "reset_release");
        applyStimulus(0, 0, 0, 0, V_RED, 2'd0, 2'b00, "reset_allred");

        // Single turn pulse at main green cycle 3.
        repeat (3) applyStimulus(0, 0, 0, 0, V_MAIN_G, 2'd0, 2'b00, "main_green");
        applyStimulus(0, 1, 0, 0, V_MAIN_G, 2'd0, 2'b00, "turn_pulse");
        repeat (4) applyStimulus(0, 0, 0, 0, V_MAIN_G, 2'd0, 2'b01, "turn_pending");
        repeat (3) applyStimulus(0, 0, 0, 0, V_MAIN_Y, 2'd0, 2'b01, "main_yellow");
        repeat (2) applyStimulus(0, 0, 0, 0, V_RED,    2'd3, 2'b01, "allred_to_turn");
        repeat (6) applyStimulus(0, 0, 0, 0, V_TURN_G, 2'd1, 2'b00, "turn_green");
        repeat (3) applyStimulus(0, 0, 0, 0, V_TURN_Y, 2'd1, 2'b00, "turn_yellow");
        repeat (2) applyStimulus(0, 0, 0, 0, V_RED,    2'd3, 2'b00, "allred_to_main");

        // Main holds past MIN_GREEN with nothing pending; then both requests together.
        repeat (10) applyStimulus(0, 0, 0, 0, V_MAIN_G, 2'd0, 2'b00, "main_hold");
        applyStimulus(0, 1, 1, 0, V_MAIN_G, 2'd0, 2'b00, "both_req");
        applyStimulus(0, 0, 0, 0, V_MAIN_G, 2'd0, 2'b11, "both_pending");
        repeat (3) applyStimulus(0, 0, 0, 0, V_MAIN_Y, 2'd0, 2'b11, "both_main_yellow");
        repeat (2) applyStimulus(0, 0, 0, 0, V_RED,    2'd3, 2'b11, "both_allred");
        repeat (6) applyStimulus(0, 0, 0, 0, V_SIDE_G, 2'd2, 2'b01, "rr_side_first");
        repeat (3) applyStimulus(0, 0, 0, 0, V_SIDE_Y, 2'd2, 2'b01, "side_yellow");
        repeat (2) applyStimulus(0, 0, 0, 0, V_RED,    2'd3, 2'b01, "side_allred");
        repeat (8) applyStimulus(0, 0, 0, 0, V_MAIN_G, 2'd0, 2'b01, "main_between");
        repeat (3) applyStimulus(0, 0, 0, 0, V_MAIN_Y, 2'd0, 2'b01, "main_yellow2");
        repeat (2) applyStimulus(0, 0, 0, 0, V_RED,    2'd3, 2'b01, "allred_turn2");
        repeat (6) applyStimulus(0, 0, 0, 0, V_TURN_G, 2'd1, 2'b00, "rr_turn_second");
        repeat (3) applyStimulus(0, 0, 0, 0, V_TURN_Y, 2'd1, 2'b00, "turn_yellow2");
        repeat (2) applyStimulus(0, 0, 0, 0, V_RED,    2'd3, 2'b00, "allred_main2");

        // req_side held through the side green entry edge: clear wins, a later pulse re-latches.
        repeat (2) applyStimulus(0, 0, 0, 0, V_MAIN_G, 2'd0, 2'b00, "main_green3");
        applyStimulus(0, 0, 1, 0, V_MAIN_G, 2'd0, 2'b00, "side_raise");
        repeat (5) applyStimulus(0, 0, 1, 0, V_MAIN_G, 2'd0, 2'b10, "side_held");
        repeat (3) applyStimulus(0, 0, 1, 0, V_MAIN_Y, 2'd0, 2'b10, "side_held_yellow");
        repeat (2) applyStimulus(0, 0, 1, 0, V_RED,    2'd3, 2'b10, "side_held_allred");
        applyStimulus(0, 0, 0, 0, V_SIDE_G, 2'd2, 2'b00, "side_clear_priority");
        applyStimulus(0, 0, 0, 0, V_SIDE_G, 2'd2, 2'b00, "side_green_idle");
        applyStimulus(0, 0, 1, 0, V_SIDE_G, 2'd2, 2'b00, "side_repulse");
        repeat (3) applyStimulus(0, 0, 0, 0, V_SIDE_G, 2'd2, 2'b10, "side_relatched");
        repeat (3) applyStimulus(0, 0, 0, 0, V_SIDE_Y, 2'd2, 2'b10, "side_yellow3");
        repeat (2) applyStimulus(0, 0, 0, 0, V_RED,    2'd3, 2'b10, "side_allred3");

        // Side was served last, so turn wins the tie; reset lands during turn green.
        applyStimulus(0, 1, 0, 0, V_MAIN_G, 2'd0, 2'b10, "turn_raise");
        repeat (7) applyStimulus(0, 0, 0, 0, V_MAIN_G, 2'd0, 2'b11, "tie_pending");
        repeat (3) applyStimulus(0, 0, 0, 0, V_MAIN_Y, 2'd0, 2'b11, "tie_yellow");
        repeat (2) applyStimulus(0, 0, 0, 0, V_RED,    2'd3, 2'b11, "tie_allred");
        applyStimulus(0, 0, 0, 0, V_TURN_G, 2'd1, 2'b10, "rr_turn_wins");
        applyStimulus(1, 0, 0, 0, V_TURN_G, 2'd1, 2'b10, "reset_mid_turn");
        applyStimulus(0, 0, 0, 0, V_RED,    2'd0, 2'b00, "reset_override");
        applyStimulus(0, 0, 0, 0, V_RED,    2'd0, 2'b00, "reset_allred2");

        // Both pending after reset: side is served, emerg arrives at side green cycle 2.
        applyStimulus(0, 1, 1, 0, V_MAIN_G, 2'd0, 2'b00, "emerg_setup");
        repeat (7) applyStimulus(0, 0, 0, 0, V_MAIN_G, 2'd0, 2'b11, "emerg_setup_pend");
        repeat (3) applyStimulus(0, 0, 0, 0, V_MAIN_Y, 2'd0, 2'b11, "emerg_setup_yellow");
        repeat (2) applyStimulus(0, 0, 0, 0, V_RED,    2'd3, 2'b11, "emerg_setup_allred");
        repeat (2) applyStimulus(0, 0, 0, 0, V_SIDE_G, 2'd2, 2'b01, "side_after_reset");
`ifdef EMERGENCY_PREEMPT_EN
        applyStimulus(0, 0, 0, 1, V_SIDE_G, 2'd2, 2'b01, "emerg_raise");
        repeat (3) applyStimulus(0, 0, 0, 1, V_SIDE_Y, 2'd2, 2'b01, "emerg_yellow");
        repeat (2) applyStimulus(0, 0, 0, 1, V_RED,    2'd3, 2'b01, "emerg_allred");
        repeat (20) applyStimulus(0, 0, 0, 1, V_MAIN_G, 2'd0, 2'b01, "emerg_hold");
        applyStimulus(0, 0, 0, 0, V_MAIN_G, 2'd0, 2'b01, "emerg_drop");
        applyStimulus(0, 0, 0, 0, V_MAIN_Y, 2'd0, 2'b01, "after_emerg");
`else
        applyStimulus(0, 0, 0, 1, V_SIDE_G, 2'd2, 2'b01, "emerg_ignored");
        repeat (3) applyStimulus(0, 0, 0, 1, V_SIDE_G, 2'd2, 2'b01, "emerg_ignored_green");
        repeat (3) applyStimulus(0, 0, 0, 0, V_SIDE_Y, 2'd2, 2'b01, "side_yellow4");
        repeat (2) applyStimulus(0, 0, 0, 0, V_RED,    2'd3, 2'b01, "side_allred4");
        repeat (2) applyStimulus(0, 0, 0, 0, V_MAIN_G, 2'd0, 2'b01, "main_after_side");
`endif

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
